// File: rtl/da_sequencer.sv
// Sequencer for a bit-serial distributed-arithmetic subfilter: accepts one sample,
// parallel-loads it, runs WORD_WIDTH shift cycles, then captures the accumulator result.
module da_sequencer #(
  parameter int WORD_WIDTH = 16  // must be >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  x_we,
  output logic [WORD_WIDTH-1:0] x,
  output logic                  en,
  output logic                  ts,
  input  logic [WORD_WIDTH-1:0] y,
  output logic                  m_valid,
  output logic [WORD_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
);
  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WORD_WIDTH - 2);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] smp;
  logic                  run;
  logic                  cap;

  // run is a one-flop release gate: nothing can be accepted until the first edge
  // after reset deasserts, so release never launches a load or shift.
  assign s_ready = run && (state == IDLE);
  assign busy    = (state != IDLE);
  assign x       = smp;
  assign cap     = (state == CAPTURE) && (!m_valid || m_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      smp     <= '0;
      run     <= 1'b0;
      x_we    <= 1'b0;
      en      <= 1'b0;
      ts      <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      run  <= 1'b1;
      x_we <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: if (s_ready && s_valid) begin
          smp   <= s_data;
          x_we  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          en    <= 1'b1;
          ts    <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: if (cnt == LAST) begin
          en    <= 1'b0;
          ts    <= 1'b0;
          state <= CAPTURE;
        end else begin
          cnt <= cnt + ONE;
          ts  <= (cnt == PENULT);  // next cycle carries the sign bit
        end
        CAPTURE: if (cap) begin
          // a capture overrides a same-cycle consume, keeping m_valid high
          m_data  <= y;
          m_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
